// File: rtl/mem_if_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM encoding and the byte-lane helper.
package mem_if_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [3:0] BE_ALL = 4'hF;
   localparam int MEM_WORD_BITS = 32;

   function automatic logic [MEM_WORD_BITS-1:0] be_mask(
      input logic [3:0] be
   );
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the load/store unit and the responder.
// master = core side, slave = memory side.
interface dmem_responder_if;
   import mem_if_pkg::*;

   logic                     req_valid;
   logic                     req_ready;
   logic                     req_write;
   logic [31:0]              req_addr;
   logic [MEM_WORD_BITS-1:0] req_wdata;
   logic [3:0]               req_be;
   logic                     resp_valid;
   logic                     resp_ready;
   logic [MEM_WORD_BITS-1:0] resp_rdata;
   logic                     resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/dmem_word_ram.sv
// Word-organised RAM: byte-enabled synchronous write, async read.
// Contents are never reset.
module dmem_word_ram
   import mem_if_pkg::*;
#(
   parameter int ADDR_WIDTH = 6
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [ADDR_WIDTH-1:0]    addr,
   input  logic [3:0]               be,
   input  logic [MEM_WORD_BITS-1:0] wdata,
   output logic [MEM_WORD_BITS-1:0] rdata
);

   logic [MEM_WORD_BITS-1:0] mem [2**ADDR_WIDTH];

   // Write the enabled byte lanes, leaving the others untouched
   always_ff @(posedge clk) begin
      if (we) begin
         if (be == BE_ALL) begin
            mem[addr] <= wdata;
         end else begin
            mem[addr] <= (mem[addr] & ~be_mask(be))
                       | (wdata & be_mask(be));
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with valid/ready handshakes.
// One request in flight, fixed wait states, error-checked access.
module dmem_responder
   import mem_if_pkg::*;
#(
   parameter int ADDR_WIDTH  = 6,
   parameter int WAIT_CYCLES = 2
) (
   input logic              clk,
   input logic              reset,
   dmem_responder_if.slave  bus
);

   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("WAIT_CYCLES must be in 0..15");
   end

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t                   state;
   state_t                   state_nx;
   logic [3:0]               cnt;
   logic [3:0]               cnt_nx;
   logic                     armed;
   logic                     accept;
   logic                     cap_write;
   logic [31:0]              cap_addr;
   logic [MEM_WORD_BITS-1:0] cap_wdata;
   logic [3:0]               cap_be;
   logic                     misalign;
   logic                     out_range;
   logic                     err;
   logic                     ram_we;
   logic [MEM_WORD_BITS-1:0] ram_rdata;
   logic [MEM_WORD_BITS-1:0] rdata_q;
   logic                     err_q;

   assign bus.req_ready  = (state == IDLE) && armed;
   assign accept         = bus.req_valid && bus.req_ready;
   assign misalign       = |cap_addr[1:0];
   assign out_range      = |cap_addr[31:ADDR_WIDTH+2];
   assign err            = misalign || out_range;
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

   // Next state, wait countdown and RAM write strobe
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      ram_we   = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               cnt_nx   = WAIT_INIT;
               state_nx = (WAIT_INIT == 4'd0) ? ACCESS : WAIT;
            end
         end
         WAIT: begin
            if (cnt <= 4'd1) begin
               state_nx = ACCESS;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         ACCESS: begin
            ram_we   = cap_write && !err;
            state_nx = RESP;
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_nx = IDLE;
            end
         end
      endcase
   end

   // State register; ready is held off until the first edge after reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         armed <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         armed <= 1'b1;
      end
   end

   // Capture the request on the accepting handshake only
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_write <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_be    <= '0;
      end else if (accept) begin
         cap_write <= bus.req_write;
         cap_addr  <= bus.req_addr;
         cap_wdata <= bus.req_wdata;
         cap_be    <= bus.req_be;
      end
   end

   // Register the response in ACCESS; held through RESP
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (state == ACCESS) begin
         err_q   <= err;
         rdata_q <= (cap_write || err) ? '0 : ram_rdata;
      end
   end

   dmem_word_ram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (cap_addr[ADDR_WIDTH+1:2]),
      .be    (cap_be),
      .wdata (cap_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 and 0 wait states)
// driven with directed and random traffic against a word-array model.
module tb_dmem_responder;
   import mem_if_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  rv = '0;
   logic [1:0]  wr = '0;
   logic [1:0]  rr = '0;
   logic [31:0] ad [2];
   logic [31:0] wd [2];
   logic [3:0]  bq [2];
   logic [1:0]  rdy;
   logic [1:0]  vld;
   logic [1:0]  er;
   logic [31:0] rd [2];

   logic [31:0] mem_m [2][64];
   int n_cmp = 0;
   int n_bad = 0;

   dmem_responder_if bus0 ();
   dmem_responder_if bus1 ();

   assign bus0.req_valid  = rv[0];
   assign bus0.req_write  = wr[0];
   assign bus0.req_addr   = ad[0];
   assign bus0.req_wdata  = wd[0];
   assign bus0.req_be     = bq[0];
   assign bus0.resp_ready = rr[0];
   assign bus1.req_valid  = rv[1];
   assign bus1.req_write  = wr[1];
   assign bus1.req_addr   = ad[1];
   assign bus1.req_wdata  = wd[1];
   assign bus1.req_be     = bq[1];
   assign bus1.resp_ready = rr[1];
   assign rdy[0] = bus0.req_ready;
   assign vld[0] = bus0.resp_valid;
   assign er[0]  = bus0.resp_err;
   assign rd[0]  = bus0.resp_rdata;
   assign rdy[1] = bus1.req_ready;
   assign vld[1] = bus1.resp_valid;
   assign er[1]  = bus1.resp_err;
   assign rd[1]  = bus1.resp_rdata;

   dmem_responder #(.ADDR_WIDTH(6), .WAIT_CYCLES(2)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0)
   );
   dmem_responder #(.ADDR_WIDTH(6), .WAIT_CYCLES(0)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit addr_bad(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'd256);
   endfunction

   // One full transaction on instance d; entered and left at a negedge
   task automatic xact(input int d, input bit w, input logic [31:0] a,
                       input logic [31:0] data, input logic [3:0] b,
                       input int stall, output logic [31:0] got);
      logic [31:0] exp_rd;
      logic [31:0] r0;
      logic        e0;
      bit          exp_err;
      int          k;
      int          lat;
      exp_err = addr_bad(a);
      exp_rd  = (w || exp_err) ? 32'd0 : mem_m[d][a[7:2]];
      if (w && !exp_err) begin
         for (int i = 0; i < 4; i++)
            if (b[i]) mem_m[d][a[7:2]][8*i +: 8] = data[8*i +: 8];
      end
      rv[d] = 1'b1; wr[d] = w; ad[d] = a; wd[d] = data; bq[d] = b;
      rr[d] = 1'b0;
      k = 0;
      while (!rdy[d] && k < 20) begin
         @(posedge clk); @(negedge clk); k++;
      end
      chk("req_ready", {31'd0, rdy[d]}, 32'd1);
      @(posedge clk); @(negedge clk);
      rv[d] = 1'b0; wr[d] = 1'($urandom); ad[d] = $urandom;
      wd[d] = $urandom; bq[d] = 4'($urandom);
      lat = 1;
      while (!vld[d] && lat < 40) begin
         @(posedge clk); @(negedge clk); lat++;
      end
      chk("latency", 32'(lat), (d == 0) ? 32'd4 : 32'd2);
      r0 = rd[d]; e0 = er[d];
      chk("resp_err", {31'd0, e0}, {31'd0, exp_err});
      chk("resp_rdata", r0, exp_rd);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); @(negedge clk);
         chk("stall_valid", {31'd0, vld[d]}, 32'd1);
         chk("stall_rdata", rd[d], r0);
         chk("stall_ready", {31'd0, rdy[d]}, 32'd0);
      end
      rr[d] = 1'b1;
      @(posedge clk); @(negedge clk);
      rr[d] = 1'b0;
      chk("idle_valid", {31'd0, vld[d]}, 32'd0);
      chk("idle_ready", {31'd0, rdy[d]}, 32'd1);
      got = r0;
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] a;
      int          d;
      int          sel;
      for (int i = 0; i < 2; i++) begin
         ad[i] = '0; wd[i] = '0; bq[i] = '0;
      end
      // reset held with a request pending
      reset = 1'b0; rv = 2'b11; rr = 2'b11;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready0", {31'd0, rdy[0]}, 32'd0);
      chk("rst_valid0", {31'd0, vld[0]}, 32'd0);
      chk("rst_rdata0", rd[0], 32'd0);
      chk("rst_err0", {31'd0, er[0]}, 32'd0);
      chk("rst_ready1", {31'd0, rdy[1]}, 32'd0);
      rv = 2'b00; rr = 2'b00;
      reset = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("rel_ready0", {31'd0, rdy[0]}, 32'd1);
      chk("rel_ready1", {31'd0, rdy[1]}, 32'd1);

      // fill both RAMs so every model word is known
      for (int dd = 0; dd < 2; dd++)
         for (int i = 0; i < 64; i++)
            xact(dd, 1'b1, 32'(i * 4), $urandom, BE_ALL, 0, got);

      // full store then load
      xact(0, 1'b1, 32'h10, 32'hDEADBEEF, BE_ALL, 0, got);
      chk("store_rdata", got, 32'd0);
      xact(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, got);
      chk("load_full", got, 32'hDEADBEEF);
      // partial store merge
      xact(0, 1'b1, 32'h10, 32'h12345678, 4'b0011, 0, got);
      xact(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, got);
      chk("load_merge", got, 32'hDEAD5678);
      // empty byte enables leave the word alone
      xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, got);
      xact(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, got);
      chk("load_be0", got, 32'hDEAD5678);
      // errors and the top boundary
      xact(0, 1'b0, 32'h12, 32'd0, 4'h0, 0, got);
      xact(0, 1'b0, 32'h100, 32'd0, 4'h0, 0, got);
      xact(0, 1'b1, 32'h100, 32'hA5A5A5A5, BE_ALL, 0, got);
      xact(0, 1'b1, 32'h13, 32'hA5A5A5A5, BE_ALL, 0, got);
      xact(0, 1'b0, 32'h0, 32'd0, 4'h0, 0, got);
      xact(0, 1'b0, 32'h10, 32'd0, 4'h0, 0, got);
      xact(0, 1'b1, 32'hFC, 32'hCAFEF00D, BE_ALL, 0, got);
      xact(0, 1'b0, 32'hFC, 32'd0, 4'h0, 0, got);
      chk("load_top", got, 32'hCAFEF00D);
      xact(0, 1'b0, 32'h8000_0000, 32'd0, 4'h0, 0, got);
      // response stall
      xact(0, 1'b0, 32'hFC, 32'd0, 4'h0, 5, got);
      xact(1, 1'b0, 32'h40, 32'd0, 4'h0, 5, got);

      // reset while a store is waiting
      rv[0] = 1'b1; wr[0] = 1'b1; ad[0] = 32'h20;
      wd[0] = 32'h0BAD0BAD; bq[0] = BE_ALL;
      @(posedge clk); @(negedge clk);
      rv[0] = 1'b0;
      reset = 1'b0;
      @(posedge clk); @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); @(negedge clk);
         chk("no_resp_after_rst", {31'd0, vld[0]}, 32'd0);
      end
      xact(0, 1'b0, 32'h20, 32'd0, 4'h0, 0, got);
      chk("reload_20", got, mem_m[0][8]);

      // zero-wait sweep
      for (int i = 0; i < 8; i++)
         xact(1, 1'b0, 32'(i * 32), 32'd0, 4'h0, 0, got);

      // random mixed traffic
      for (int i = 0; i < 200; i++) begin
         d   = int'($urandom_range(0, 1));
         sel = int'($urandom_range(0, 7));
         a   = 32'($urandom_range(0, 63)) * 4;
         if (sel == 0) a = a | 32'($urandom_range(1, 3));
         else if (sel == 1) a = $urandom | 32'h100;
         xact(d, 1'($urandom), a, $urandom, 4'($urandom),
              int'($urandom_range(0, 2)), got);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
